// File: rtl/comp_frame_rx_if.sv
// comp_frame_rx_if: FWFT read port of the comp_frame_rx output FIFO.
// master = FIFO owner (comp_frame_rx), slave = consumer (e.g. bram_fifo drain).
interface comp_frame_rx_if;
  logic        fifo_read_next;
  logic [31:0] fifo_data_out;
  logic        fifo_empty;

  modport master (input fifo_read_next, output fifo_data_out, output fifo_empty);
  modport slave  (output fifo_read_next, input fifo_data_out, input fifo_empty);
endinterface

// File: rtl/comp_frame_rx.sv
// comp_frame_rx: N_CH-channel comparator frame capture packing tagged words into a FWFT FIFO.
// Define COMP_FRAME_RX_TRAILER_EN to append a timestamp trailer word after each frame.
module comp_frame_rx #(
  parameter int          N_CH       = 4,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [3:0]  IDENTIFIER = 4'b0010
) (
  input  logic            seq_clk,
  input  logic            rst,
  input  logic [4:0]      n_bits,
  input  logic            sen,
  input  logic            cap_en,
  input  logic [N_CH-1:0] comp_in,
  comp_frame_rx_if.master fifo,
  output logic            frame_done,
  output logic            busy,
  output logic [7:0]      lost_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef COMP_FRAME_RX_TRAILER_EN
  localparam logic [2:0] LAST_IDX = 3'(N_CH);
`else
  localparam logic [2:0] LAST_IDX = 3'(N_CH - 1);
`endif
  localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, EMIT, WAIT_LOW} state_t;
  state_t state, state_nxt;

  logic        sen_q, sen_rise;
  logic [4:0]  len, bit_cnt, cnt_inc, len_clamped;
  logic [19:0] shreg [N_CH];
  logic [2:0]  ch_idx, word_ch;
  logic        partial, part_nxt;
  logic [3:0]  frame_cnt;
  logic        start, shift, emit_word, emit_last;
  logic [19:0] word_data;
  logic [31:0] word;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, occ;
  logic        full, empty, push, pop;

  assign sen_rise    = sen & ~sen_q;
  assign cnt_inc     = bit_cnt + 5'd1;
  assign len_clamped = (n_bits == 5'd0 || n_bits > 5'd20) ? 5'd20 : n_bits;
  assign busy        = (state != IDLE);

  always_ff @(posedge seq_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift     = 1'b0;
    emit_word = 1'b0;
    emit_last = 1'b0;
    part_nxt  = partial;
    case (state)
      IDLE: begin
        if (sen_rise) begin
          start     = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        shift = cap_en;
        // Reaching the programmed length wins over sen dropping in the same cycle.
        if (cap_en && cnt_inc == len) begin
          part_nxt  = 1'b0;
          state_nxt = EMIT;
        end else if (!sen) begin
          part_nxt  = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        emit_word = 1'b1;
        if (ch_idx == LAST_IDX) begin
          emit_last = 1'b1;
          state_nxt = sen ? WAIT_LOW : IDLE;
        end
      end
      WAIT_LOW: begin
        if (!sen) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef COMP_FRAME_RX_TRAILER_EN
  logic [19:0] ts_cnt, ts_lat;

  always_ff @(posedge seq_clk) begin
    if (rst) begin
      ts_cnt <= '0;
      ts_lat <= '0;
    end else begin
      ts_cnt <= ts_cnt + 20'd1;
      if (start) ts_lat <= ts_cnt;
    end
  end
`endif

  always_comb begin
    word_data = '0;
    word_ch   = ch_idx;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_idx == i[2:0]) word_data = shreg[i];
    end
`ifdef COMP_FRAME_RX_TRAILER_EN
    if (ch_idx == LAST_IDX) begin
      word_data = ts_lat;
      word_ch   = 3'b111;
    end
`endif
  end

  assign word = {IDENTIFIER, word_ch, partial, frame_cnt, word_data};

  always_ff @(posedge seq_clk) begin
    if (rst) begin
      sen_q      <= 1'b0;
      len        <= 5'd20;
      bit_cnt    <= '0;
      ch_idx     <= '0;
      partial    <= 1'b0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      lost_count <= '0;
      for (int unsigned i = 0; i < N_CH; i++) shreg[i] <= '0;
    end else begin
      sen_q      <= sen;
      frame_done <= emit_last;
      partial    <= part_nxt;
      if (start) begin
        len     <= len_clamped;
        bit_cnt <= '0;
        ch_idx  <= '0;
        for (int unsigned i = 0; i < N_CH; i++) shreg[i] <= '0;
      end
      if (shift) begin
        bit_cnt <= cnt_inc;
        for (int unsigned i = 0; i < N_CH; i++) shreg[i] <= {shreg[i][18:0], comp_in[i]};
      end
      if (emit_word) ch_idx <= emit_last ? 3'd0 : ch_idx + 3'd1;
      if (emit_last) frame_cnt <= frame_cnt + 4'd1;
      if (emit_word && full && lost_count != 8'hFF) lost_count <= lost_count + 8'd1;
    end
  end

  // Full is judged on the pre-pop occupancy, so a same-cycle pop never rescues a write.
  assign occ   = wr_ptr - rd_ptr;
  assign full  = (occ == DEPTH_W);
  assign empty = (occ == '0);
  assign push  = emit_word & ~full;
  assign pop   = fifo.fifo_read_next & ~empty;

  always_ff @(posedge seq_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge seq_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= word;
  end

  assign fifo.fifo_empty    = empty;
  assign fifo.fifo_data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule
